adc_to_opfb_deadlock_reporter: RTL and testbench

//  Consumes the block/axis_block_info outputs of the adc_to_opfb deadlock monitor and

---
 rtl/adc_to_opfb_dbg_pkg.sv | 16 +
 rtl/adc_to_opfb_sat_counter.sv | 24 ++
 rtl/adc_to_opfb_deadlock_reporter.sv | 129 ++++++++++++
 tb/tb_adc_to_opfb_deadlock_reporter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_to_opfb_dbg_pkg.sv
// Shared types and default widths for the adc_to_opfb debug/deadlock reporting slice.
package adc_to_opfb_dbg_pkg;

    localparam int unsigned INFO_W    = 9;
    localparam int unsigned TS_W      = 32;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned CH_INFO_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_LATCHED = 2'd2,
        ST_REARM   = 2'd3
    } dl_state_e;

endpackage

// File: rtl/adc_to_opfb_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module adc_to_opfb_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/adc_to_opfb_deadlock_reporter.sv
// Qualifies the per-cycle deadlock monitor flag into a latched event with
// info/timestamp snapshot, saturating event count and a one-cycle irq.
module adc_to_opfb_deadlock_reporter #(
    parameter int unsigned INFO_W      = adc_to_opfb_dbg_pkg::INFO_W,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned TS_W        = adc_to_opfb_dbg_pkg::TS_W,
    parameter int unsigned CNT_W       = adc_to_opfb_dbg_pkg::CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              block_in,
    input  logic [INFO_W-1:0] axis_info_in,
    input  logic              clear,
    output logic              deadlock_flag,
    output logic [INFO_W-1:0] deadlock_info,
    output logic [TS_W-1:0]   deadlock_time,
    output logic [CNT_W-1:0]  event_count,
    output logic              irq
);

    import adc_to_opfb_dbg_pkg::*;

    localparam int unsigned      HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    dl_state_e         state_q;
    dl_state_e         state_d;
    logic              qualify_c;
    logic              hold_en_c;
    logic              hold_clr_c;
    logic [HOLD_W-1:0] hold_q;
    logic [TS_W-1:0]   ts_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A held-over deadlock must be released (REARM) before it can qualify again.
    always_comb begin
        state_d    = state_q;
        qualify_c  = 1'b0;
        hold_en_c  = 1'b0;
        hold_clr_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (block_in) begin
                    if (HOLD_CYCLES == 1) begin
                        qualify_c = 1'b1;
                        state_d   = ST_LATCHED;
                    end else begin
                        hold_en_c = 1'b1;
                        state_d   = ST_QUAL;
                    end
                end
            end
            ST_QUAL: begin
                if (!block_in) begin
                    hold_clr_c = 1'b1;
                    state_d    = ST_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    qualify_c  = 1'b1;
                    hold_clr_c = 1'b1;
                    state_d    = ST_LATCHED;
                end else begin
                    hold_en_c = 1'b1;
                end
            end
            ST_LATCHED: begin
                if (clear) begin
                    state_d = ST_REARM;
                end
            end
            ST_REARM: begin
                if (!block_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    adc_to_opfb_sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (hold_clr_c),
        .en    (hold_en_c),
        .count (hold_q)
    );

    adc_to_opfb_sat_counter #(.WIDTH(CNT_W)) u_event_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .en    (qualify_c),
        .count (event_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Snapshot registers; info/time keep their last values after clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deadlock_flag <= 1'b0;
            deadlock_info <= '0;
            deadlock_time <= '0;
            irq           <= 1'b0;
        end else begin
            irq <= qualify_c;
            if (qualify_c) begin
                deadlock_flag <= 1'b1;
                deadlock_info <= axis_info_in;
                deadlock_time <= ts_q;
            end else if ((state_q == ST_LATCHED) && clear) begin
                deadlock_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_to_opfb_deadlock_reporter.sv
// Bench for adc_to_opfb_deadlock_reporter: three configurations driven in parallel
// and compared every cycle against a run-length reference model.
module tb_adc_to_opfb_deadlock_reporter;

    logic       clock;
    logic       reset;
    logic       block_in;
    logic       clear;
    logic [8:0] axis_info_in;

    logic        flag_a, irq_a, flag_b, irq_b, flag_c, irq_c;
    logic [8:0]  info_a, info_b, info_c;
    logic [31:0] time_a, time_b, time_c;
    logic [15:0] cnt_a, cnt_c;
    logic [1:0]  cnt_b;

    int checks   = 0;
    int failures = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    adc_to_opfb_deadlock_reporter #(.HOLD_CYCLES(16), .CNT_W(16)) u_a (
        .clock(clock), .reset(reset), .block_in(block_in), .axis_info_in(axis_info_in),
        .clear(clear), .deadlock_flag(flag_a), .deadlock_info(info_a),
        .deadlock_time(time_a), .event_count(cnt_a), .irq(irq_a));

    adc_to_opfb_deadlock_reporter #(.HOLD_CYCLES(4), .CNT_W(2)) u_b (
        .clock(clock), .reset(reset), .block_in(block_in), .axis_info_in(axis_info_in),
        .clear(clear), .deadlock_flag(flag_b), .deadlock_info(info_b),
        .deadlock_time(time_b), .event_count(cnt_b), .irq(irq_b));

    adc_to_opfb_deadlock_reporter #(.HOLD_CYCLES(1), .CNT_W(16)) u_c (
        .clock(clock), .reset(reset), .block_in(block_in), .axis_info_in(axis_info_in),
        .clear(clear), .deadlock_flag(flag_c), .deadlock_info(info_c),
        .deadlock_time(time_c), .event_count(cnt_c), .irq(irq_c));

    // Reference model: one entry per instance
    int          hold_p[3] = '{16, 4, 1};
    int          cmax[3]   = '{65535, 3, 65535};
    int          run[3];
    bit          lat[3], wrel[3];
    bit          m_flag[3], m_irq[3];
    logic [8:0]  m_info[3];
    logic [31:0] m_time[3];
    int          m_cnt[3];
    logic [31:0] m_ts;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            run[i] = 0; lat[i] = 0; wrel[i] = 0; m_flag[i] = 0; m_irq[i] = 0;
            m_info[i] = '0; m_time[i] = '0; m_cnt[i] = 0;
        end
        m_ts = '0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit q;
            q = 0;
            m_irq[i] = 0;
            if (lat[i]) begin
                if (clear) begin lat[i] = 0; wrel[i] = 1; m_flag[i] = 0; end
            end else if (wrel[i]) begin
                if (!block_in) wrel[i] = 0;
            end else if (block_in) begin
                run[i]++;
                if (run[i] >= hold_p[i]) q = 1;
            end else begin
                run[i] = 0;
            end
            if (q) begin
                m_flag[i] = 1; m_irq[i] = 1; m_info[i] = axis_info_in; m_time[i] = m_ts;
                if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                run[i] = 0; lat[i] = 1;
            end
        end
        m_ts = m_ts + 32'd1;
    endtask

    task automatic check_all();
        logic        f[3], r[3];
        logic [8:0]  inf[3];
        logic [31:0] tm[3];
        logic [15:0] c[3];
        f   = '{flag_a, flag_b, flag_c};
        r   = '{irq_a, irq_b, irq_c};
        inf = '{info_a, info_b, info_c};
        tm  = '{time_a, time_b, time_c};
        c   = '{cnt_a, 16'(cnt_b), cnt_c};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("flag[%0d]", i), 32'(f[i]), 32'(m_flag[i]));
            chk($sformatf("irq[%0d]", i), 32'(r[i]), 32'(m_irq[i]));
            chk($sformatf("info[%0d]", i), 32'(inf[i]), 32'(m_info[i]));
            chk($sformatf("time[%0d]", i), tm[i], m_time[i]);
            chk($sformatf("count[%0d]", i), 32'(c[i]), 32'(m_cnt[i]));
        end
    endtask

    // Called at a negedge: drive, clock once, check at the following negedge
    task automatic step(input bit b, input logic [8:0] inf, input bit clr);
        block_in = b; axis_info_in = inf; clear = clr;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    // Async reset asserted between edges; outputs must drop before any clock edge
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_flag_a", 32'(flag_a), 32'd0);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_time_a", time_a, 32'd0);
        chk("rst_flag_b", 32'(flag_b), 32'd0);
        chk("rst_cnt_b", 32'(cnt_b), 32'd0);
        chk("rst_flag_c", 32'(flag_c), 32'd0);
        chk("rst_info_c", 32'(info_c), 32'd0);
        model_reset();
        check_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        bit b;
        bit clr;
        bit e_flag;
        bit e_irq;
        int e_cnt;
    } vec_t;
    vec_t tbl[11];

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 1, 1};
        tbl[2]  = '{1, 0, 1, 0, 1};
        tbl[3]  = '{1, 1, 0, 0, 1};
        tbl[4]  = '{1, 0, 0, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 1};
        tbl[6]  = '{1, 0, 1, 1, 2};
        tbl[7]  = '{0, 1, 0, 0, 2};
        tbl[8]  = '{1, 0, 0, 0, 2};
        tbl[9]  = '{0, 0, 0, 0, 2};
        tbl[10] = '{1, 0, 1, 1, 3};

        reset = 1'b1; block_in = 1'b0; clear = 1'b0; axis_info_in = '0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all();
        reset = 1'b0;

        // HOLD=16 qualify latency, info and timestamp snapshot
        async_reset();
        for (int k = 0; k < 15; k++) step(1, 9'h1FE, 0);
        chk("t1_flag_early", 32'(flag_a), 32'd0);
        step(1, 9'h1FE, 0);
        chk("t1_flag", 32'(flag_a), 32'd1);
        chk("t1_irq", 32'(irq_a), 32'd1);
        chk("t1_info", 32'(info_a), 32'h1FE);
        chk("t1_time", time_a, 32'd15);
        chk("t1_count", 32'(cnt_a), 32'd1);
        step(1, 9'h1FE, 0);
        chk("t1_irq_once", 32'(irq_a), 32'd0);

        // Clear while still blocked, no re-trigger until released
        step(1, 9'h055, 1);
        chk("t3_flag_cleared", 32'(flag_a), 32'd0);
        chk("t3_info_held", 32'(info_a), 32'h1FE);
        for (int k = 0; k < 20; k++) step(1, 9'h0AA, 0);
        chk("t3_no_retrigger", 32'(cnt_a), 32'd1);
        step(0, 9'h000, 0);
        for (int k = 0; k < 16; k++) step(1, 9'h123, 0);
        chk("t3_count2", 32'(cnt_a), 32'd2);
        chk("t3_info2", 32'(info_a), 32'h123);

        // Glitch mid-qualification restarts the hold window
        async_reset();
        for (int k = 0; k < 15; k++) step(1, 9'h011, 0);
        step(0, 9'h011, 0);
        for (int k = 0; k < 15; k++) step(1, 9'h022, 0);
        chk("t2_no_event", 32'(flag_a), 32'd0);
        step(1, 9'h033, 0);
        chk("t2_event", 32'(cnt_a), 32'd1);
        chk("t2_info", 32'(info_a), 32'h033);

        // Clear in IDLE and during QUAL has no effect on timing
        async_reset();
        step(0, 9'h000, 1);
        for (int k = 0; k < 15; k++) step(1, 9'h044, (k == 3 || k == 9));
        chk("t4_flag_early", 32'(flag_a), 32'd0);
        step(1, 9'h045, 1);
        chk("t4_flag", 32'(flag_a), 32'd1);

        // Table vectors checked on the HOLD_CYCLES=1 instance
        async_reset();
        for (int v = 0; v < 11; v++) begin
            step(tbl[v].b, 9'(9'h100 + v), tbl[v].clr);
            chk($sformatf("tbl%0d_flag", v), 32'(flag_c), 32'(tbl[v].e_flag));
            chk($sformatf("tbl%0d_irq", v), 32'(irq_c), 32'(tbl[v].e_irq));
            chk($sformatf("tbl%0d_cnt", v), 32'(cnt_c), 32'(tbl[v].e_cnt));
        end

        // Saturating CNT_W=2 counter on the HOLD=4 instance
        async_reset();
        for (int e = 0; e < 5; e++) begin
            int irqs;
            irqs = 0;
            for (int k = 0; k < 4; k++) begin
                step(1, 9'(e), 0);
                if (irq_b) irqs++;
            end
            chk($sformatf("t5_irq_ev%0d", e), 32'(irqs), 32'd1);
            chk($sformatf("t5_cnt_ev%0d", e), 32'(cnt_b), (e < 3) ? 32'(e + 1) : 32'd3);
            step(1, 9'(e), 1);
            step(0, 9'(e), 0);
        end

        // Reset while in QUAL
        for (int k = 0; k < 5; k++) step(1, 9'h0F0, 0);
        async_reset();

        // Randomized run against the model
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 15) != 0, 9'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
